// File: rtl/enc_pri_skid_pkg.sv
// Shared types for the registered priority encoder: handshake states and the buffered entry.
package enc_pkg;

  localparam int MULTI_CNT_W = 8;
  // Widest index an entry can carry (N_IN up to 256)
  localparam int IDX_MAX_W   = 8;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 any;
    logic                 multi;
  } entry_t;

endpackage

// File: rtl/enc_pri_skid_core.sv
// Combinational N-to-log2(N) priority encoder; ENC_MULTIHOT_CHK_EN adds the multi-hot flag.
module enc_pri_core #(
  parameter int N_IN    = 4,
  parameter int IDX_W   = $clog2(N_IN),
  parameter int LSB_PRI = 1
) (
  input  logic [N_IN-1:0]  req,
  output logic [IDX_W-1:0] idx,
  output logic             any
`ifdef ENC_MULTIHOT_CHK_EN
  ,
  output logic             multi
`endif
);

  // Scan toward the winning end so the last hit assigned is the winner
  always_comb begin
    idx = '0;
    if (LSB_PRI != 0) begin
      for (int i = N_IN - 1; i >= 0; i--)
        if (req[i]) idx = IDX_W'(i);
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any = |req;

`ifdef ENC_MULTIHOT_CHK_EN
  // Clearing the lowest set bit leaves something only if two or more were set
  assign multi = |(req & (req - {{(N_IN-1){1'b0}}, 1'b1}));
`endif

endmodule

// File: rtl/enc_pri_skid.sv
// Registered priority encoder with valid/ready on both sides and a 2-entry skid buffer.
// Optional multi-hot flag and saturating counter under macro ENC_MULTIHOT_CHK_EN.
module enc_pri_skid
  import enc_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int IDX_W   = $clog2(N_IN),
  parameter int LSB_PRI = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN-1:0]        in_req,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_any
`ifdef ENC_MULTIHOT_CHK_EN
  ,
  output logic                   out_multi,
  output logic [MULTI_CNT_W-1:0] multi_cnt
`endif
);

  state_t           state_q, state_d;
  entry_t           main_q, main_d, skid_q, skid_d, enc_e;
  logic             in_ready_q;
  logic [IDX_W-1:0] core_idx;
  logic             core_any;
  logic             core_multi;
  logic             accept, pop;

`ifdef ENC_MULTIHOT_CHK_EN
  enc_pri_core #(.N_IN(N_IN), .IDX_W(IDX_W), .LSB_PRI(LSB_PRI)) u_core (
    .req(in_req), .idx(core_idx), .any(core_any), .multi(core_multi)
  );
`else
  enc_pri_core #(.N_IN(N_IN), .IDX_W(IDX_W), .LSB_PRI(LSB_PRI)) u_core (
    .req(in_req), .idx(core_idx), .any(core_any)
  );
  assign core_multi = 1'b0;
`endif

  // Encode at accept time; the skid holds encoded entries, never raw requests
  always_comb begin
    enc_e                = '0;
    enc_e.idx[IDX_W-1:0] = core_idx;
    enc_e.any            = core_any;
    enc_e.multi          = core_multi;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = enc_e;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          state_d = ST_TWO;
          skid_d  = enc_e;
        end else if (pop && !accept) begin
          state_d = ST_EMPTY;
        end else if (accept && pop) begin
          main_d  = enc_e;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  assign out_idx = main_q.idx[IDX_W-1:0];
  assign out_any = main_q.any;

  // Upper index bits are always zero and multi is unused without the macro
  logic unused_bits;
  assign unused_bits = ^{main_q.idx, main_q.multi};

`ifdef ENC_MULTIHOT_CHK_EN
  logic [MULTI_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (accept && enc_e.multi && (cnt_q != {MULTI_CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign out_multi = main_q.multi;
  assign multi_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_enc_pri_skid.sv
// Directed bench for enc_pri_skid with a scoreboard queue; builds with or without ENC_MULTIHOT_CHK_EN.
module tb_enc_pri_skid;

  localparam int N_IN  = 4;
  localparam int IDX_W = 2;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             any;
    logic             multi;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [N_IN-1:0]  in_req;
  logic             out_ready;
  logic             in_ready, out_valid, out_any;
  logic [IDX_W-1:0] out_idx;
  logic             in_ready1, out_valid1, out_any1;
  logic [IDX_W-1:0] out_idx1;
`ifdef ENC_MULTIHOT_CHK_EN
  logic             out_multi, out_multi1;
  logic [7:0]       multi_cnt, multi_cnt1;
`endif

  int   total = 0;
  int   passes = 0;
  int   cyc = 0;
  int   pop_cnt = 0;
  bit   lat_chk = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  enc_pri_skid #(.N_IN(N_IN), .LSB_PRI(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_any(out_any)
`ifdef ENC_MULTIHOT_CHK_EN
    , .out_multi(out_multi), .multi_cnt(multi_cnt)
`endif
  );

  // MSB-priority instance on the same input stream, always drained
  enc_pri_skid #(.N_IN(N_IN), .LSB_PRI(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_req(in_req),
    .out_valid(out_valid1), .out_ready(1'b1), .out_idx(out_idx1), .out_any(out_any1)
`ifdef ENC_MULTIHOT_CHK_EN
    , .out_multi(out_multi1), .multi_cnt(multi_cnt1)
`endif
  );

  function automatic exp_t model(input logic [N_IN-1:0] r, input int c);
    exp_t e;
    e.idx   = '0;
    e.any   = (r != '0);
    e.multi = ($countones(r) > 1);
    e.cyc   = c;
    for (int i = 0; i < N_IN; i++)
      if (r[i]) begin
        e.idx = IDX_W'(i);
        break;
      end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: push on accept, pop and compare on output transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        total++;
        assert (q.size() != 0) passes++;
        else $error("FAIL sb_unexpected: observed output idx %0d expected none", out_idx);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("sb_idx", 32'(out_idx), 32'(e.idx));
          chk("sb_any", 32'(out_any), 32'(e.any));
`ifdef ENC_MULTIHOT_CHK_EN
          chk("sb_multi", 32'(out_multi), 32'(e.multi));
`endif
          if (lat_chk) chk("sb_latency", 32'(cyc - e.cyc), 32'd1);
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_req, cyc));
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [N_IN-1:0] r);
    int n = 0;
    in_valid = 1'b1;
    in_req   = r;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0, c0;
    logic [N_IN-1:0] mh[4];
    mh[0] = 4'b0011; mh[1] = 4'b1100; mh[2] = 4'b1010; mh[3] = 4'b1111;
    rst_n = 1'b0; in_valid = 1'b0; in_req = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_any", 32'(out_any), 0);
`ifdef ENC_MULTIHOT_CHK_EN
    chk("rst_out_multi", 32'(out_multi), 0);
    chk("rst_multi_cnt", 32'(multi_cnt), 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single entry, one-cycle latency
    out_ready = 1'b1;
    send(4'b0100);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_idx", 32'(out_idx), 2);
    chk("single_any", 32'(out_any), 1);
    drain();

    // Priority, both polarities
    send(4'b1010);
    chk("pri_lsb_idx", 32'(out_idx), 1);
    chk("pri_msb_valid", 32'(out_valid1), 1);
    chk("pri_msb_idx", 32'(out_idx1), 3);
    drain();

    // Zero request still passes
    send(4'b0000);
    chk("zero_valid", 32'(out_valid), 1);
    chk("zero_any", 32'(out_any), 0);
    chk("zero_idx", 32'(out_idx), 0);
    drain();

    // Backpressure: two entries fill the buffer, third is held off
    out_ready = 1'b0;
    p0 = pop_cnt;
    send(4'b0001);
    send(4'b0010);
    in_valid = 1'b1;
    in_req   = 4'b1000;
    repeat (2) @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_out_idx_held", 32'(out_idx), 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(4'b1000);
    drain();
    chk("bp_pop_count", 32'(pop_cnt - p0), 3);

    // Streaming: one accept and one output per cycle
    lat_chk = 1;
    p0 = pop_cnt;
    c0 = cyc;
    for (int i = 0; i < 16; i++) send(N_IN'($urandom_range(0, 15)));
    chk("stream_cycles", 32'(cyc - c0), 16);
    drain();
    chk("stream_pop_count", 32'(pop_cnt - p0), 16);
    lat_chk = 0;

    // Reset with buffered entries drops them
    out_ready = 1'b0;
    send(4'b0001);
    send(4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_stale", 32'(out_valid), 0);
    chk("midrst_in_ready_after", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    send(4'b0100);
    drain();

`ifdef ENC_MULTIHOT_CHK_EN
    // Multi-hot flag and saturating counter
    do_reset();
    send(4'b0110);
    chk("multi_flag", 32'(out_multi), 1);
    chk("multi_cnt_one", 32'(multi_cnt), 1);
    drain();
    for (int i = 0; i < 300; i++) send(mh[i % 4]);
    chk("multi_cnt_sat", 32'(multi_cnt), 255);
    drain();
    send(4'b0001);
    chk("multi_cnt_single_hot", 32'(multi_cnt), 255);
    chk("multi_flag_clear", 32'(out_multi), 0);
    drain();
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
